// File: rtl/conv_frame_capture.sv
// conv_frame_capture: writes the convolution pixel stream into frame memory, bottom row first.
module conv_frame_capture #(
  parameter int WORD_SIZE    = 8,
  parameter int IMAGE_WIDTH  = 540,
  parameter int IMAGE_HEIGHT = 360,
  parameter int SKIP_COUNT   = 0,
  parameter int ADDR_WIDTH   = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_SIZE-1:0]  outputPixel,
  input  logic                  pixelValid,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WORD_SIZE-1:0]  memData,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  droppedPixel
);
  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] LP_W     = ADDR_WIDTH'(IMAGE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LP_WM1   = ADDR_WIDTH'(IMAGE_WIDTH-1);
  localparam logic [ADDR_WIDTH-1:0] LP_HM1   = ADDR_WIDTH'(IMAGE_HEIGHT-1);
  localparam logic [ADDR_WIDTH-1:0] LP_BASE0 = ADDR_WIDTH'((IMAGE_HEIGHT-1)*IMAGE_WIDTH);
  localparam logic [16:0]           LP_SKIP  = 17'(SKIP_COUNT);
  state_t                  r_state, w_next;
  logic [ADDR_WIDTH-1:0]   r_row, r_col, r_base, r_addr;
  logic [WORD_SIZE-1:0]    r_data;
  logic [15:0]             r_skip;
  logic [16:0]             w_skip_inc;
  logic                    r_wr_en, r_last, r_dropped;
  logic                    w_accept, w_start, w_drop, w_skip_step;
  assign w_skip_inc  = {1'b0, r_skip} + 17'd1;
  assign w_start     = !abort && r_state == S_IDLE && start;
  assign w_drop      = !abort && pixelValid && (r_state == S_IDLE || r_state == S_DONE);
  assign w_skip_step = !abort && pixelValid && r_state == S_SKIP;
  // r_last holds CAPTURE for the final write cycle so busy drops together with frameDone
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    if (abort) w_next = S_IDLE;
    else
      case (r_state)
        S_IDLE:    w_next = start ? ((SKIP_COUNT == 0) ? S_CAPTURE : S_SKIP) : S_IDLE;
        S_SKIP:    w_next = (pixelValid && w_skip_inc == LP_SKIP) ? S_CAPTURE : S_SKIP;
        S_CAPTURE: begin
          w_next   = r_last ? S_DONE : S_CAPTURE;
          w_accept = !r_last && pixelValid;
        end
        default:   w_next = S_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_row     <= LP_HM1;
      r_col     <= '0;
      r_base    <= LP_BASE0;
      r_skip    <= '0;
      r_last    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wr_en   <= w_accept;
      r_dropped <= w_start ? pixelValid : (r_dropped | w_drop);
      if (w_start) begin
        r_row  <= LP_HM1;
        r_col  <= '0;
        r_base <= LP_BASE0;
        r_skip <= '0;
        r_last <= 1'b0;
      end
      if (w_skip_step) r_skip <= w_skip_inc[15:0];
      if (w_accept) begin
        r_addr <= r_base + r_col;
        r_data <= outputPixel;
        r_last <= r_row == '0 && r_col == LP_WM1;
        r_col  <= (r_col == LP_WM1) ? '0 : r_col + 1'b1;
        r_row  <= (r_col == LP_WM1) ? r_row - 1'b1 : r_row;
        r_base <= (r_col == LP_WM1) ? r_base - LP_W : r_base;
      end
    end
  end
  assign memWrEn      = r_wr_en;
  assign memAddr      = r_addr;
  assign memData      = r_data;
  assign busy         = r_state == S_SKIP || r_state == S_CAPTURE;
  assign frameDone    = r_state == S_DONE;
  assign droppedPixel = r_dropped;
endmodule
